// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier family.
// Provides the FSM state type, default operand width and counter sizing.
package mult_pkg;

  localparam int MULT_N = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/product valid-ready bundle between the operand register stage,
// the Booth multiplier and the MACC accumulator.
interface booth_seq_mult_if #(
  parameter int N = mult_pkg::MULT_N
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,q_1}. Purely combinational.
module booth_step #(
  parameter int N = mult_pkg::MULT_N
) (
  input  logic [N:0]   acc_i,
  input  logic [N-1:0] q_i,
  input  logic         q1_i,
  input  logic [N:0]   m_i,
  output logic [N:0]   acc_o,
  output logic [N-1:0] q_o,
  output logic         q1_o
);

  logic [N:0] sum;

  always_comb begin
    sum = acc_i;
    unique case ({q_i[0], q1_i})
      2'b01:   sum = acc_i + m_i;
      2'b10:   sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
  end

  // Sign of the widened accumulator is replicated into the vacated MSB.
  assign acc_o = {sum[N], sum[N:1]};
  assign q_o   = {sum[0], q_i[N-1:1]};
  assign q1_o  = q_i[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: N iteration cycles per signed product,
// valid/ready on both sides, one operation in flight at a time.
module booth_seq_mult
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input logic             clk,
  input logic             rst,
  booth_seq_mult_if.slave bus
);

  localparam int            CW       = clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     m_q, m_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [2*N-1:0] p_q, p_d;

  logic [N:0]     step_acc;
  logic [N-1:0]   step_q;
  logic           step_q1;

  booth_step #(.N(N)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q1_i  (q1_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q),
    .q1_o  (step_q1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          m_d     = {bus.a[N-1], bus.a};
          q_d     = bus.b;
          acc_d   = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        q1_d  = step_q1;
        cnt_d = cnt_q + 1'b1;
        // Final step: product is the low 2N bits of the shifted {A,Q}.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          p_d     = {step_acc[N-1:0], step_q};
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;

endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential radix-2 Booth multiplier for the MACC datapath. It sits directly downstream of the N-bit operand register stage and consumes the registered signed operands. It produces a 2N-bit signed product after N iteration cycles, which feeds the MACC accumulator. A valid/ready handshake on both sides lets the upstream register stage stall while a multiply is in flight.

## Interface
- N, 9: operand width in bits, signed two's complement; N ≥ 2
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  N  multiplicand, signed
- b  input  N  multiplier, signed
- out_valid  output  1  product p valid
- out_ready  input  1  downstream accepts p
- p  output  2N  signed product a*b

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE, step counter=0, p=0, out_valid=0, in_ready=1 (decoded from state). in_valid is ignored in any cycle where rst=1.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch M=sign-extended a (N+1 bits), Q=b, A=0 (N+1 bits), q_1=0, count=0; go to RUN.
- RUN, one Booth step per cycle:
  - {Q[0],q_1}=01 → A+=M; 10 → A−=M; 00/11 → no op.
  - Then arithmetic right shift of {A,Q,q_1} by 1.
  - count increments. After step N (count==N−1 at the edge), go to DONE and load p={A,Q}[2N−1:0] from the post-shift value.
- DONE:
  - out_valid=1, p stable.
  - On out_ready: go to IDLE, out_valid=0. p holds its last value until the next product loads.
- The N+1-bit A makes a=−2^(N−1) exact. The full product range fits 2N bits without overflow: (−2^(N−1))² = 2^(2N−2) < 2^(2N−1).
- No operand overlap: in_ready=0 in RUN and DONE, so upstream must hold a/b and in_valid.
- rst asserted in any state aborts the operation; the partial product is discarded.

## Timing
- Input handshake at edge k.
- RUN occupies edges k+1 … k+N.
- out_valid=1 and p valid from edge k+N (visible in cycle k+N).
- Minimum issue interval N+2 cycles: input handshake, N steps, output handshake edge, return to IDLE.
- out_ready held high in DONE: IDLE at edge k+N+1, in_ready=1 in the following cycle.
- out_ready low: DONE held indefinitely, with p and out_valid constant.
- out_ready while not in DONE: ignored.
- in_valid=1 with out_ready=1 in DONE: only the output handshake happens. The input is taken at the first IDLE cycle.
- rst=1 at edge t: state IDLE, out_valid=0, p=0 from cycle t. in_ready=1 from cycle t.
- Outputs are registered or state-decoded only. No combinational path from inputs to outputs.

## Structure
- Shared package mult_pkg:
  - state enum {IDLE, RUN, DONE}
  - default width constant MULT_N=9
  - counter width function clog2(N)
- Sub-module booth_step: purely combinational. Takes A, Q, q_1, M and returns the next A, Q, q_1 after one add/sub and shift. It is reused by any future unrolled/pipelined variant.
- Top holds the FSM, counter, operand/accumulator registers and output register.

## Test plan
- a=3, b=5, out_ready=1 → in_ready drops for N+1 cycles; out_valid at handshake+9; p=18'h0000F.
- a=−256 (9'h100), b=−256 → p=18'h10000 (65536, no overflow).
- a=255, b=−1 → p=18'h3FF01 (−255); a=0, b=9'h1A3 → p=0.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid stays 1, p stable, in_ready=0. New in_valid held is accepted only after out_ready rises.
- Reset mid-RUN after 4 steps → next cycle out_valid=0, p=0, in_ready=1. A following a=−7, b=9 gives p=18'h3FFC1 (−63).
- Randomized back-to-back: 1000 random a/b pairs with random out_ready gaps → every p equals the sign-extended a*b, and no operand is lost or duplicated.
